// File: rtl/screen_arbiter.sv
// screen_arbiter: sequencer and arbiter for the single framebuffer write port.
// Tracks the display mode (title / game-over / play). Every mode change wipes
// the screen with a raster clear sweep, pulses the new mode's drawer start
// strobe, then grants that drawer exclusive write access until the next change.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   showTitle, showGameOver       mode requests from the splash state machine
//   {title,over,game}_req/x/y/colour  drawer pixel write requests
//   {title,over,game}_go          one-cycle start strobe to the drawer
//   {title,over,game}_grant       drawer owns the write port
//   plot, plot_x, plot_y, plot_colour  framebuffer write port (registered)
//   clearing                      outputs carry clear-sweep pixels
module screen_arbiter #(
    parameter int unsigned WIDTH   = 160,
    parameter int unsigned HEIGHT  = 120,
    parameter int unsigned X_W     = 8,
    parameter int unsigned Y_W     = 7,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               showTitle,
    input  logic               showGameOver,
    input  logic               title_req,
    input  logic [X_W-1:0]     title_x,
    input  logic [Y_W-1:0]     title_y,
    input  logic [COLOR_W-1:0] title_colour,
    input  logic               over_req,
    input  logic [X_W-1:0]     over_x,
    input  logic [Y_W-1:0]     over_y,
    input  logic [COLOR_W-1:0] over_colour,
    input  logic               game_req,
    input  logic [X_W-1:0]     game_x,
    input  logic [Y_W-1:0]     game_y,
    input  logic [COLOR_W-1:0] game_colour,
    output logic               title_go,
    output logic               over_go,
    output logic               game_go,
    output logic               title_grant,
    output logic               over_grant,
    output logic               game_grant,
    output logic               plot,
    output logic [X_W-1:0]     plot_x,
    output logic [Y_W-1:0]     plot_y,
    output logic [COLOR_W-1:0] plot_colour,
    output logic               clearing
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        MODE_TITLE = 2'd0,
        MODE_OVER  = 2'd1,
        MODE_PLAY  = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_START = 2'd1,
        ST_SERVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d, mode_dec_c;
    logic [X_W-1:0]   cx_q, cx_d;
    logic [Y_W-1:0]   cy_q, cy_d;

    // Bit 0 = title, bit 1 = game-over, bit 2 = play
    logic [2:0]       go_d, grant_d, mode_oh_c;
    logic             plot_d, clearing_d;
    logic [X_W-1:0]   plot_x_d;
    logic [Y_W-1:0]   plot_y_d;
    logic [COLOR_W-1:0] plot_colour_d;

    logic             sel_req_c;
    logic [X_W-1:0]   sel_x_c;
    logic [Y_W-1:0]   sel_y_c;
    logic [COLOR_W-1:0] sel_colour_c;

    // Mode decode: title has priority over game-over
    always_comb begin
        if (showTitle) begin
            mode_dec_c = MODE_TITLE;
        end else if (showGameOver) begin
            mode_dec_c = MODE_OVER;
        end else begin
            mode_dec_c = MODE_PLAY;
        end
    end

    // Drawer currently being served: one-hot and its request mux
    always_comb begin
        mode_oh_c    = 3'b000;
        sel_req_c    = 1'b0;
        sel_x_c      = '0;
        sel_y_c      = '0;
        sel_colour_c = '0;
        case (mode_q)
            MODE_TITLE: begin
                mode_oh_c    = 3'b001;
                sel_req_c    = title_req;
                sel_x_c      = title_x;
                sel_y_c      = title_y;
                sel_colour_c = title_colour;
            end
            MODE_OVER: begin
                mode_oh_c    = 3'b010;
                sel_req_c    = over_req;
                sel_x_c      = over_x;
                sel_y_c      = over_y;
                sel_colour_c = over_colour;
            end
            MODE_PLAY: begin
                mode_oh_c    = 3'b100;
                sel_req_c    = game_req;
                sel_x_c      = game_x;
                sel_y_c      = game_y;
                sel_colour_c = game_colour;
            end
            default: ;
        endcase
    end

    // Next state and next registered outputs; a mode change overrides every state
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        go_d          = 3'b000;
        grant_d       = 3'b000;
        plot_d        = 1'b0;
        plot_x_d      = '0;
        plot_y_d      = '0;
        plot_colour_d = '0;
        clearing_d    = 1'b0;

        if (mode_dec_c != mode_q) begin
            // Outputs stay idle this cycle; the new sweep starts next cycle
            state_d = ST_CLEAR;
            mode_d  = mode_dec_c;
            cx_d    = '0;
            cy_d    = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    plot_d     = 1'b1;
                    plot_x_d   = cx_q;
                    plot_y_d   = cy_q;
                    clearing_d = 1'b1;
                    if (cx_q == X_LAST) begin
                        cx_d = '0;
                        if (cy_q == Y_LAST) begin
                            cy_d    = '0;
                            state_d = ST_START;
                        end else begin
                            cy_d = cy_q + Y_W'(1);
                        end
                    end else begin
                        cx_d = cx_q + X_W'(1);
                    end
                end
                ST_START: begin
                    go_d    = mode_oh_c;
                    state_d = ST_SERVE;
                end
                ST_SERVE: begin
                    grant_d = mode_oh_c;
                    if (sel_req_c) begin
                        plot_d        = 1'b1;
                        plot_x_d      = sel_x_c;
                        plot_y_d      = sel_y_c;
                        plot_colour_d = sel_colour_c;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CLEAR;
            mode_q      <= MODE_TITLE;
            cx_q        <= '0;
            cy_q        <= '0;
            title_go    <= 1'b0;
            over_go     <= 1'b0;
            game_go     <= 1'b0;
            title_grant <= 1'b0;
            over_grant  <= 1'b0;
            game_grant  <= 1'b0;
            plot        <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
            clearing    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            title_go    <= go_d[0];
            over_go     <= go_d[1];
            game_go     <= go_d[2];
            title_grant <= grant_d[0];
            over_grant  <= grant_d[1];
            game_grant  <= grant_d[2];
            plot        <= plot_d;
            plot_x      <= plot_x_d;
            plot_y      <= plot_y_d;
            plot_colour <= plot_colour_d;
            clearing    <= clearing_d;
        end
    end

endmodule

// File: tb/tb_screen_arbiter.sv
// Testbench for screen_arbiter: per-cycle comparison against a behavioural
// model plus directed literal checks of the key sequencing points.
module tb_screen_arbiter;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int NPIX   = WIDTH * HEIGHT;

    logic       clk = 1'b0;
    logic       rst;
    logic       showTitle, showGameOver;
    logic       title_req, over_req, game_req;
    logic [7:0] title_x, over_x, game_x;
    logic [6:0] title_y, over_y, game_y;
    logic [2:0] title_colour, over_colour, game_colour;
    logic       title_go, over_go, game_go;
    logic       title_grant, over_grant, game_grant;
    logic       plot, clearing;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    screen_arbiter dut (
        .clk(clk), .rst(rst),
        .showTitle(showTitle), .showGameOver(showGameOver),
        .title_req(title_req), .title_x(title_x), .title_y(title_y), .title_colour(title_colour),
        .over_req(over_req), .over_x(over_x), .over_y(over_y), .over_colour(over_colour),
        .game_req(game_req), .game_x(game_x), .game_y(game_y), .game_colour(game_colour),
        .title_go(title_go), .over_go(over_go), .game_go(game_go),
        .title_grant(title_grant), .over_grant(over_grant), .game_grant(game_grant),
        .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .clearing(clearing)
    );

    always #5 clk = ~clk;

    // Output bundle: {plot, x, y, colour, clearing, go{t,o,g}, grant{t,o,g}}
    logic [25:0] act_vec;
    assign act_vec = {plot, plot_x, plot_y, plot_colour, clearing,
                      title_go, over_go, game_go, title_grant, over_grant, game_grant};

    // Behavioural model: m_t counts cycles since the current mode was (re)entered.
    // 0..NPIX-1 are clear pixels in raster order, NPIX is the go strobe, beyond is serving.
    int          m_mode = 0;   // 0 title, 1 game-over, 2 play
    int          m_t    = 0;
    int          m_dec;
    logic [25:0] exp_vec = '0;
    logic        e_plot, e_clr;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
    logic [2:0]  e_c, e_go, e_gr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  = 0;
            m_t     = 0;
            exp_vec = '0;
        end else begin
            m_dec  = showTitle ? 0 : (showGameOver ? 1 : 2);
            e_plot = 1'b0; e_clr = 1'b0; e_x = '0; e_y = '0; e_c = '0; e_go = '0; e_gr = '0;
            if (m_dec != m_mode) begin
                m_mode = m_dec;
                m_t    = 0;
            end else if (m_t < NPIX) begin
                e_plot = 1'b1;
                e_clr  = 1'b1;
                e_x    = 8'(m_t % WIDTH);
                e_y    = 7'(m_t / WIDTH);
                m_t    = m_t + 1;
            end else if (m_t == NPIX) begin
                e_go = 3'b100 >> m_mode;
                m_t  = m_t + 1;
            end else begin
                e_gr = 3'b100 >> m_mode;
                if (m_mode == 0 && title_req) begin
                    e_plot = 1'b1; e_x = title_x; e_y = title_y; e_c = title_colour;
                end else if (m_mode == 1 && over_req) begin
                    e_plot = 1'b1; e_x = over_x; e_y = over_y; e_c = over_colour;
                end else if (m_mode == 2 && game_req) begin
                    e_plot = 1'b1; e_x = game_x; e_y = game_y; e_c = game_colour;
                end
            end
            exp_vec = {e_plot, e_x, e_y, e_c, e_clr, e_go, e_gr};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs from the current falling edge until a go strobe or the budget expires
    task automatic run_clear(input int budget, output int n_clr, output int lx, output int ly,
                             output logic [2:0] gos);
        n_clr = 0; lx = -1; ly = -1; gos = 3'b000;
        for (int i = 0; i < budget; i++) begin
            if (plot && clearing) begin
                n_clr++;
                lx = int'(plot_x);
                ly = int'(plot_y);
            end
            if ({title_go, over_go, game_go} != 3'b000) begin
                gos = {title_go, over_go, game_go};
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_first_pixel(input string name);
        chk(name, {plot, plot_x, plot_y, plot_colour, clearing}, {1'b1, 8'd0, 7'd0, 3'd0, 1'b1});
    endtask

    task automatic chk_idle(input string name);
        chk(name, {plot, clearing, title_grant, over_grant, game_grant}, 5'b0);
    endtask

    int         n_clr, lx, ly;
    logic [2:0] gos;

    initial begin
        rst = 1'b0;
        showTitle = 1'b1; showGameOver = 1'b1;
        title_req = 1'b0; title_x = '0; title_y = '0; title_colour = '0;
        over_req  = 1'b0; over_x  = '0; over_y  = '0; over_colour  = '0;
        game_req  = 1'b0; game_x  = '0; game_y  = '0; game_colour  = '0;

        fork
            begin : compare_loop
                forever begin
                    @(negedge clk);
                    if (cmp_en) chk("cycle_model", 32'(act_vec), 32'(exp_vec));
                end
            end
            begin : stimulus
                // Reset state, both mode requests high
                repeat (3) @(negedge clk);
                chk("reset_outputs", 32'(act_vec), 32'd0);
                rst    = 1'b1;
                cmp_en = 1'b1;
                @(negedge clk);
                chk_first_pixel("title_first_clear");
                run_clear(NPIX + 10, n_clr, lx, ly, gos);
                chk("title_clear_len", 32'(n_clr), 32'd19200);
                chk("title_last_x", 32'(lx), 32'd159);
                chk("title_last_y", 32'(ly), 32'd119);
                chk("both_high_title_go", 32'(gos), 32'b100);

                // Served writes: only the granted drawer reaches the port
                title_req = 1'b1; title_x = 8'd5; title_y = 7'd7; title_colour = 3'd3;
                game_req  = 1'b1; game_x  = 8'd9; game_y  = 7'd9; game_colour  = 3'd5;
                showGameOver = 1'b0;
                @(negedge clk);
                chk("title_grant", {29'd0, title_grant, over_grant, game_grant}, 32'b100);
                chk("go_single", {29'd0, title_go, over_go, game_go}, 32'b000);
                @(negedge clk);
                chk("title_write", {plot, plot_x, plot_y, plot_colour}, {1'b1, 8'd5, 7'd7, 3'd3});
                title_req = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("game_ignored", {31'd0, plot}, 32'd0);
                game_req = 1'b0;

                // Switch to play while the title drawer keeps requesting
                title_req = 1'b1; title_x = 8'd1; title_y = 7'd2; title_colour = 3'd6;
                showTitle = 1'b0;
                @(negedge clk);
                chk_idle("switch_grants_drop");
                @(negedge clk);
                chk_first_pixel("play_first_clear");
                repeat (499) @(negedge clk);
                chk("play_pixel_499", {plot_x, plot_y, clearing}, {8'd19, 7'd3, 1'b1});

                // Change during clear restarts the sweep
                showGameOver = 1'b1;
                @(negedge clk);
                chk_idle("restart_idle");
                @(negedge clk);
                chk_first_pixel("over_first_clear");
                run_clear(NPIX + 10, n_clr, lx, ly, gos);
                chk("over_clear_len", 32'(n_clr), 32'd19200);
                chk("over_go", 32'(gos), 32'b010);
                over_req = 1'b1; over_x = 8'd100; over_y = 7'd50; over_colour = 3'd7;
                @(negedge clk);
                chk("over_grant", {29'd0, title_grant, over_grant, game_grant}, 32'b010);
                @(negedge clk);
                chk("over_write", {plot, plot_x, plot_y, plot_colour}, {1'b1, 8'd100, 7'd50, 3'd7});
                over_req = 1'b0; title_req = 1'b0;

                // Game-over to play: full clear, game_go, game_grant
                showGameOver = 1'b0;
                @(negedge clk);
                chk_idle("play_switch_idle");
                @(negedge clk);
                chk_first_pixel("play2_first_clear");
                run_clear(NPIX + 10, n_clr, lx, ly, gos);
                chk("play_clear_len", 32'(n_clr), 32'd19200);
                chk("game_go", 32'(gos), 32'b001);
                game_req = 1'b1; game_x = 8'd159; game_y = 7'd119; game_colour = 3'd2;
                @(negedge clk);
                chk("game_grant", {29'd0, title_grant, over_grant, game_grant}, 32'b001);
                @(negedge clk);
                chk("game_write_corner", {plot, plot_x, plot_y, plot_colour}, {1'b1, 8'd159, 7'd119, 3'd2});
                repeat (3) @(negedge clk);

                // Asynchronous reset mid-serve, between clock edges
                #2;
                rst = 1'b0;
                showTitle = 1'b1;
                #1;
                chk("midreset_outputs", 32'(act_vec), 32'd0);
                @(negedge clk);
                rst = 1'b1;
                game_req = 1'b0;
                @(negedge clk);
                chk_first_pixel("midreset_first_clear");
                repeat (200) @(negedge clk);

                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join_any
    end

endmodule
